// File: rtl/rs_issue_scheduler.sv
// ---------------------------------------------------------------------------
// rs_issue_scheduler
//
// Select stage of the reservation station. Every cycle it picks at most one
// ready entry for each functional-unit class, scanning from a per-class
// rotating pointer. It keeps no more than ISSUE_W of those picks, giving
// lower class indices priority. The kept picks go back to the RS at once as
// a clear mask. A registered issue packet goes to the FUs on the next cycle.
//
// Ports:
//   clock        sole clock, all state updates on posedge
//   reset        synchronous, active-high
//   flush        mispredict squash, same effect on state as reset
//   entry_valid  [RS_SZ]        entry occupied
//   entry_ready  [RS_SZ]        all source operands available
//   entry_fu     [RS_SZ*FU_W]   FU class of each entry (entry e at e*FU_W)
//   fu_avail     [NUM_FU]       class f can accept an op at the next edge
//   entry_clear  [RS_SZ]        combinational mask of entries granted now
//   issue_valid  [NUM_FU]       registered, class f has an op this cycle
//   issue_idx    [NUM_FU*IDX_W] registered RS index for class f
//   issue_count  [clog2(ISSUE_W+1)] registered popcount of issue_valid
// ---------------------------------------------------------------------------
module rs_issue_scheduler #(
  parameter int RS_SZ   = 16,
  parameter int NUM_FU  = 4,
  parameter int ISSUE_W = 2,
  parameter int IDX_W   = $clog2(RS_SZ),
  parameter int FU_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [RS_SZ-1:0]              entry_valid,
  input  logic [RS_SZ-1:0]              entry_ready,
  input  logic [RS_SZ*FU_W-1:0]         entry_fu,
  input  logic [NUM_FU-1:0]             fu_avail,
  output logic [RS_SZ-1:0]              entry_clear,
  output logic [NUM_FU-1:0]             issue_valid,
  output logic [NUM_FU*IDX_W-1:0]       issue_idx,
  output logic [$clog2(ISSUE_W+1)-1:0]  issue_count
);

  localparam int CNT_W = $clog2(ISSUE_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RS_SZ - 1);

  // Rotating start position of the scan for each class.
  logic [IDX_W-1:0] ptr [NUM_FU];

  // Per-class candidate vectors, tentative grants and the capped grants.
  logic [RS_SZ-1:0]  cand [NUM_FU];
  logic [NUM_FU-1:0] tent_valid;
  logic [IDX_W-1:0]  tent_idx [NUM_FU];
  logic [NUM_FU-1:0] kept;
  logic [CNT_W-1:0]  kept_count;
  logic              squash;

  assign squash = reset | flush;

  // Add an offset to a base index and wrap it modulo RS_SZ. RS_SZ need not
  // be a power of two, so the wrap is an explicit subtraction. It is not a
  // bit truncation. base is always below RS_SZ and offs below RS_SZ, so a
  // single subtraction is enough.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= RS_SZ) begin
      sum = sum - RS_SZ;
    end
    return IDX_W'(sum);
  endfunction

  // An entry is a candidate for class f when it is occupied, ready, and
  // tagged with class f. Each entry carries a single class tag, so it can
  // show up in only one class vector. That guarantees an entry is never
  // granted twice in the same cycle.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      cand[f] = '0;
      for (int e = 0; e < RS_SZ; e++) begin
        cand[f][e] = entry_valid[e] & entry_ready[e] &
                     (entry_fu[e*FU_W +: FU_W] == FU_W'(f));
      end
    end
  end

  // Per-class rotating-priority pick. The scan starts at ptr[f] and wraps
  // from RS_SZ-1 back to 0. The first candidate found wins. A class whose
  // FU cannot accept an op produces no tentative grant at all.
  always_comb begin
    tent_valid = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      tent_idx[f] = '0;
    end
    for (int f = 0; f < NUM_FU; f++) begin
      if (fu_avail[f]) begin
        for (int k = 0; k < RS_SZ; k++) begin
          if (!tent_valid[f] && cand[f][wrap_idx(ptr[f], k)]) begin
            tent_valid[f] = 1'b1;
            tent_idx[f]   = wrap_idx(ptr[f], k);
          end
        end
      end
    end
  end

  // Width cap. Tentative grants are kept in ascending class order until
  // ISSUE_W of them have been taken. Dropped classes behave as though they
  // got nothing this cycle, so they do not advance their pointers.
  always_comb begin
    kept       = '0;
    kept_count = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (tent_valid[f] && (kept_count < CNT_W'(ISSUE_W))) begin
        kept[f]    = 1'b1;
        kept_count = kept_count + 1'b1;
      end
    end
  end

  // Clear mask back to the RS. While reset or flush is asserted no entry
  // may be freed, because the matching issue would be squashed at the edge
  // and the op would be lost.
  always_comb begin
    entry_clear = '0;
    if (!squash) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (kept[f]) begin
          entry_clear[tent_idx[f]] = 1'b1;
        end
      end
    end
  end

  // State update. A kept grant moves its class pointer one past the granted
  // entry, wrapping at RS_SZ-1, and loads the issue packet. Classes without
  // a kept grant drop issue_valid. They keep their pointer and last index.
  // Reset and flush both return everything to zero. Reset takes priority,
  // but both have the same effect.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int f = 0; f < NUM_FU; f++) begin
        ptr[f] <= '0;
      end
      issue_valid <= '0;
      issue_idx   <= '0;
      issue_count <= '0;
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (kept[f]) begin
          ptr[f] <= (tent_idx[f] == LAST_IDX) ? '0 : tent_idx[f] + IDX_W'(1);
          issue_valid[f] <= 1'b1;
          issue_idx[f*IDX_W +: IDX_W] <= tent_idx[f];
        end else begin
          issue_valid[f] <= 1'b0;
        end
      end
      issue_count <= kept_count;
    end
  end

endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Select stage for the reservation station. Each cycle it picks at most one ready RS entry per functional-unit class, limited to ISSUE_W grants in total, using a rotating-priority pointer per FU class. It returns a one-hot clear mask to the RS in the same cycle and presents a registered issue packet to the FUs one cycle later. It sits between the RS entry array and the FU issue ports.

## Interface
- RS_SZ, 16: RS entries; any value ≥ 2, need not be a power of two.
- NUM_FU, 4: FU classes; any value ≥ 1.
- ISSUE_W, 2: maximum grants per cycle, 1..NUM_FU.
- IDX_W, $clog2(RS_SZ): entry index width.
- FU_W, max(1,$clog2(NUM_FU)): FU class width.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  mispredict squash; same effect as reset on this block's state.
- entry_valid  in  RS_SZ  entry occupied.
- entry_ready  in  RS_SZ  all source operands available.
- entry_fu  in  RS_SZ×FU_W  FU class of each entry.
- fu_avail  in  NUM_FU  class f can accept an op issued at the next edge.
- entry_clear  out  RS_SZ  combinational one-hot-per-grant mask; RS frees these entries at this edge.
- issue_valid  out  NUM_FU  registered; class f has an op this cycle.
- issue_idx  out  NUM_FU×IDX_W  registered RS index issued to class f.
- issue_count  out  $clog2(ISSUE_W+1)  registered popcount of issue_valid.

## Operation
- Candidate(e,f) = entry_valid[e] & entry_ready[e] & (entry_fu[e]==f).
- Per class f, when fu_avail[f]=1: pick the first candidate scanning e = ptr[f], ptr[f]+1, …, wrapping from RS_SZ-1 to 0. This yields one tentative grant per class.
- Width cap: keep tentative grants in ascending class index (class 0 highest priority) until ISSUE_W are kept. Drop the rest; dropped classes do not advance their pointers.
- entry_clear[e]=1 iff e was kept for some class. An entry belongs to exactly one class, so it is never granted twice.
- Pointer update on each kept grant for class f: ptr[f] <= (idx==RS_SZ-1) ? 0 : idx+1. Pointers of classes with no kept grant hold.
- Registered outputs:
  - kept class f: issue_valid[f]<=1, issue_idx[f]<=idx.
  - otherwise: issue_valid[f]<=0, issue_idx[f] holds.
- flush=1 or reset=1: entry_clear forced to 0 combinationally. At the edge, all ptr<=0, issue_valid<=0, issue_idx<=0, issue_count<=0. Reset and flush together behave as reset.
- Grant selection is a function of the current inputs and ptr only; there are no other FSM states.

## Timing
- Reset values: issue_valid=0, issue_idx=0, issue_count=0, all ptr=0. entry_clear is 0 while reset is held.
- Select latency: entry_clear is valid in the same cycle as entry_ready; issue_* follow 1 cycle later.
- Back-to-back operation: an entry that becomes ready in cycle t can be cleared in t and issued in t+1. No bubble between consecutive grants to the same class.
- fu_avail is sampled only in the grant cycle. A class with fu_avail=0 gets no grant; its issue_valid is 0 in the next cycle.
- No ready candidates anywhere: entry_clear=0, all issue_valid fall to 0 next cycle, pointers hold.
- Wrap boundary: with ptr=RS_SZ-1, entry RS_SZ-1 is scanned first, then 0.
- Flush in the same cycle as a would-be grant: no clear, no issue, pointers reset.

## Test plan
- Reset: hold reset 2 cycles with all entries valid and ready → entry_clear=0 throughout; one cycle after release, issue_valid=0 and issue_count=0.
- Round-robin: RS_SZ=16, entries 3, 7, 12 all class 1 and always ready, fu_avail=4'b0010, RS re-asserts entries after clear → issue_idx[1] sequence 3, 7, 12, 3 on successive cycles.
- Width cap: ISSUE_W=2, one ready entry in each of classes 0..3 (entries 0, 1, 2, 3), all fu_avail=1 → entry_clear=16'h0003, next cycle issue_valid=4'b0011, issue_count=2; ptr[2] and ptr[3] remain 0.
- Wrap: ptr[0] driven to 15 via a grant at entry 14; ready class-0 entries at 2 and 15 → entry 15 is granted, then entry 2 on the following cycle.
- FU back-pressure: class 2 has ready entry 5, fu_avail[2]=0 for 3 cycles then 1 → no clear during the 3 cycles; clear of bit 5 in cycle 4; issue_valid[2]=1 with issue_idx[2]=5 in cycle 5.
- Flush: ready entries present and flush pulsed for 1 cycle → entry_clear=0 that cycle, next cycle issue_valid=0 and all pointers 0; a grant resumes normally the cycle after.
